// File: rtl/ahb_lite_req_arbiter.sv
// AHB-Lite single-master front end: NUM_REQ requesters share one master port, one NONSEQ per grant.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module ahb_lite_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*3-1:0]      req_size,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         HADDR,
   output logic [1:0]                HTRANS,
   output logic                      HWRITE,
   output logic [2:0]                HSIZE,
   output logic [DATA_W-1:0]         HWDATA,
   input  logic [DATA_W-1:0]         HRDATA,
   input  logic                      HREADY,
   input  logic                      HRESP
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     owner_q;
   logic [IDX_W-1:0]     win_idx;
   logic [NUM_REQ-1:0]   win_oh;
   logic                 win_vld;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [ADDR_W-1:0]    addr_q, sel_addr;
   logic                 write_q, sel_write;
   logic [2:0]           size_q, sel_size;
   logic [DATA_W-1:0]    wdata_q, sel_wdata;
   logic [DATA_W-1:0]    rdata_q;
   logic                 err_q;

`ifdef AHB_ARB_FIXED_PRIO_EN
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      win_oh  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!win_vld && req[i]) begin
            win_vld   = 1'b1;
            win_idx   = IDX_W'(i);
            win_oh[i] = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr_q;

   // Two ascending passes (above the pointer, then wrapping) give the ptr+1 modulo search.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      win_oh  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!win_vld && req[i] && (IDX_W'(i) > rr_ptr_q)) begin
            win_vld   = 1'b1;
            win_idx   = IDX_W'(i);
            win_oh[i] = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!win_vld && req[i] && (IDX_W'(i) <= rr_ptr_q)) begin
            win_vld   = 1'b1;
            win_idx   = IDX_W'(i);
            win_oh[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      else if (state_q == ST_RESP)
         rr_ptr_q <= owner_q;
   end
`endif

   always_comb begin
      sel_addr  = '0;
      sel_write = 1'b0;
      sel_size  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) begin
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_write = req_write[i];
            sel_size  = req_size[i*3 +: 3];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      HTRANS  = 2'b00;
      ack     = '0;
      case (state_q)
         ST_IDLE: if (win_vld) state_d = ST_ADDR;
         ST_ADDR: begin
            HTRANS = 2'b10;
            if (HREADY) state_d = ST_DATA;
         end
         ST_DATA: if (HREADY) state_d = ST_RESP;
         ST_RESP: begin
            ack[owner_q] = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         owner_q <= '0;
         gnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (win_vld) begin
               owner_q <= win_idx;
               gnt_q   <= win_oh;
               addr_q  <= sel_addr;
               write_q <= sel_write;
               size_q  <= sel_size;
               wdata_q <= sel_wdata;
            end
            ST_DATA: if (HREADY) begin
               rdata_q <= HRDATA;
               err_q   <= HRESP;
            end
            ST_RESP: gnt_q <= '0;
            default: ;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign HADDR     = addr_q;
   assign HWRITE    = write_q;
   assign HSIZE     = size_q;
   assign HWDATA    = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
